// File: rtl/data_mem_responder.sv
// Multi-cycle, handshaked word store for the pipeline data-memory port.
// A single request is accepted, held for LATENCY wait cycles, then answered with a one-cycle response.
module data_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                write_q;
    logic [IDX_W-1:0]    idx_q;
    logic [1:0]          boff_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                ready_q;
    logic                valid_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];

    logic                done_s;
    logic                mem_we_s;
    logic                unused_addr_s;

    // Upper address bits only select aliases of the same word.
    assign unused_addr_s = ^req_addr[ADDR_W-1:IDX_W+2];

    assign done_s   = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we_s = done_s && write_q && (boff_q == 2'b00);

    assign stall      = ((state_q == S_IDLE) && req_valid) || (state_q == S_WAIT);
    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Request sequencing FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            idx_q   <= '0;
            boff_q  <= 2'b00;
            wdata_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        idx_q   <= req_addr[IDX_W+1:2];
                        boff_q  <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        cnt_q   <= CNT_INIT;
                        ready_q <= 1'b0;
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_RESP;
                        valid_q <= 1'b1;
                        err_q   <= (boff_q != 2'b00);
                        if (!write_q) begin
                            rdata_q <= mem_q[idx_q];
                        end else begin
                            rdata_q <= rdata_q;
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Word storage; deliberately not reset so contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: one LATENCY=3 instance for the access table, one LATENCY=1 instance for back-to-back loads.
module tb_data_mem_responder;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;

    logic        valid3, wr3, ready3, rvalid3, err3, stall3;
    logic [31:0] addr3, wdata3, rdata3;
    logic        valid1, wr1, ready1, rvalid1, err1, stall1;
    logic [31:0] addr1, wdata1, rdata1;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q3[$];
    exp_t q1[$];
    exp_t e3, e1;
    vec_t vecs[12];
    logic [31:0] b2b_data[3];

    data_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(valid3), .req_write(wr3), .req_addr(addr3),
        .req_wdata(wdata3), .req_ready(ready3), .resp_valid(rvalid3), .resp_rdata(rdata3),
        .resp_err(err3), .stall(stall3)
    );

    data_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(valid1), .req_write(wr1), .req_addr(addr1),
        .req_wdata(wdata1), .req_ready(ready1), .resp_valid(rvalid1), .resp_rdata(rdata1),
        .resp_err(err1), .stall(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboards: every response pops the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rvalid3) begin
            if (q3.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp3: got resp_valid=1 expected none at %0t", $time);
            end else begin
                e3 = q3.pop_front();
                chk32("rdata3", rdata3, e3.rdata);
                chk1("err3", err3, e3.err);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rvalid1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp1: got resp_valid=1 expected none at %0t", $time);
            end else begin
                e1 = q1.pop_front();
                chk32("rdata1", rdata1, e1.rdata);
                chk1("err1", err1, e1.err);
            end
        end
    end

    // One access on the LATENCY=3 instance with cycle-exact handshake checks.
    task automatic access3(input vec_t v);
        @(negedge clk);
        valid3 = 1'b1; wr3 = v.wr; addr3 = v.addr; wdata3 = v.wdata;
        q3.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        #1;
        chk1("ready_c0", ready3, 1'b1);
        chk1("stall_c0", stall3, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            valid3 = 1'b0; addr3 = ~v.addr; wdata3 = ~v.wdata; wr3 = ~v.wr;
            #1;
            chk1("stall_wait", stall3, 1'b1);
            chk1("ready_wait", ready3, 1'b0);
            chk1("rvalid_wait", rvalid3, 1'b0);
        end
        @(negedge clk);
        #1;
        chk1("rvalid_resp", rvalid3, 1'b1);
        chk1("stall_resp", stall3, 1'b0);
        chk1("ready_resp", ready3, 1'b0);
        @(negedge clk);
        #1;
        chk1("ready_idle", ready3, 1'b1);
        chk1("rvalid_idle", rvalid3, 1'b0);
        chk1("stall_idle", stall3, 1'b0);
    endtask

    // Store on the LATENCY=1 instance, waiting a bounded time for its response.
    task automatic store1(input logic [31:0] a, input logic [31:0] d);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        valid1 = 1'b1; wr1 = 1'b1; addr1 = a; wdata1 = d;
        q1.push_back('{rdata: 32'h0, err: 1'b0});
        @(negedge clk);
        valid1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!seen) begin
                @(negedge clk);
                #1;
                seen = rvalid1;
            end
        end
        chk1("store1_resp_seen", seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0040, 32'h1111_1111, 32'h1234_5678, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0042, 32'hAAAA_5555, 32'h1234_5678, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0040, 32'h0,         32'h1111_1111, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0043, 32'h0,         32'h1111_1111, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0080, 32'h0BAD_C0DE, 32'h1111_1111, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0FFC, 32'h5A5A_5A5A, 32'h1111_1111, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_3FFC, 32'h0,         32'h5A5A_5A5A, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_1000, 32'h0,         32'h1234_5678, 1'b0};
        b2b_data[0] = 32'h1111_0000;
        b2b_data[1] = 32'h2222_0004;
        b2b_data[2] = 32'h3333_0008;

        rst = 1'b0;
        valid3 = 1'b0; wr3 = 1'b0; addr3 = 32'h0; wdata3 = 32'h0;
        valid1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;

        // Reset asserted mid-cycle must take effect before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk1("rst_async_ready", ready3, 1'b1);
        chk1("rst_async_rvalid", rvalid3, 1'b0);
        chk1("rst_async_stall", stall3, 1'b0);
        chk32("rst_async_rdata", rdata3, 32'h0);
        chk1("rst_async_err", err3, 1'b0);
        chk1("rst_async_ready1", ready1, 1'b1);
        #19 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk1("idle_ready", ready3, 1'b1);
            chk1("idle_stall", stall3, 1'b0);
            chk1("idle_rvalid", rvalid3, 1'b0);
        end

        for (int i = 0; i < 12; i++) begin
            access3(vecs[i]);
        end

        // Store abandoned by reset in the second wait cycle.
        @(negedge clk);
        valid3 = 1'b1; wr3 = 1'b1; addr3 = 32'h0000_0080; wdata3 = 32'hCAFE_F00D;
        @(negedge clk);
        valid3 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("midrst_ready", ready3, 1'b1);
        chk1("midrst_stall", stall3, 1'b0);
        chk1("midrst_rvalid", rvalid3, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk1("midrst_idle_ready", ready3, 1'b1);
        access3('{1'b0, 32'h0000_0080, 32'h0, 32'h0BAD_C0DE, 1'b0});

        for (int i = 0; i < 3; i++) begin
            store1(32'(4 * i), b2b_data[i]);
        end

        // Back-to-back loads on LATENCY=1 with req_valid held high.
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            valid1 = 1'b1; wr1 = 1'b0; addr1 = 32'(4 * (c / 3)); wdata1 = 32'hFFFF_FFFF;
            if (c % 3 == 0) begin
                q1.push_back('{rdata: b2b_data[c / 3], err: 1'b0});
            end
            #1;
            chk1($sformatf("b2b_ready_c%0d", c), ready1, (c % 3 == 0));
            chk1($sformatf("b2b_rvalid_c%0d", c), rvalid1, (c % 3 == 2));
            chk1($sformatf("b2b_stall_c%0d", c), stall1, (c % 3 != 2));
        end
        @(negedge clk);
        valid1 = 1'b0;
        #1;
        chk1("b2b_end_ready", ready1, 1'b1);
        chk1("b2b_end_stall", stall1, 1'b0);
        repeat (3) @(negedge clk);

        chk32("q3_drained", 32'(q3.size()), 32'd0);
        chk32("q1_drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port. It replaces the zero-latency combinational DataMemory with a multi-cycle, handshaked word store.
- Accepts one load or store request at a time and models a fixed access latency. It returns read data or a write acknowledge, and drives a stall signal that freezes the pipeline while an access is outstanding.
- Sits between the EX_MEM register outputs (address, write data, mem read/write controls) and the MEM_WB register input.

Parameters:
- ADDR_W, 32, request address width in bits (byte address).
- DATA_W, 32, data word width in bits.
- DEPTH_WORDS, 1024, number of words in storage. Power of two, at least 2.
- LATENCY, 3, number of WAIT cycles between request accept and response. Range 1..15.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present. Driven from mem_read OR write_enable of the EX_MEM stage.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  one-cycle pulse: response available.
- resp_rdata  out  DATA_W  load data. Valid when resp_valid=1 and the request was a load.
- resp_err  out  1  misaligned access flag. Valid with resp_valid.
- stall  out  1  pipeline must hold PC, IF_ID, ID_EX and EX_MEM.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE and the counter to 0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. stall follows its combinational equation (0 if req_valid=0).
  - Storage array is NOT cleared.
  - An outstanding access is abandoned; a pending store is never committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1:
    - Latch req_write, req_addr and req_wdata into internal registers.
    - Load counter with LATENCY-1.
    - Go to WAIT.
  - With req_valid=0, stay in IDLE.
- WAIT:
  - req_ready=0. Request inputs are ignored; the latched copy is used.
  - If counter != 0, decrement.
  - If counter == 0, go to RESP. On that same edge:
    - Store: write the latched data to array[index], unless misaligned.
    - Load: register array[index] into resp_rdata.
    - Register resp_err = (addr[1:0] != 0).
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Next edge returns unconditionally to IDLE and clears resp_valid.
  - resp_rdata holds its value until the next load response.
- Index: latched addr[log2(DEPTH_WORDS)+1 : 2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4 bytes.
- Misaligned access (addr[1:0] != 0):
  - Store is suppressed (array unchanged).
  - Load returns the word at the truncated index.
  - resp_err=1 in both cases.
- stall equation (combinational): stall = (state==IDLE && req_valid) || state==WAIT.
  - stall=0 in RESP, so the pipeline advances on the RESP edge and MEM_WB captures resp_rdata.
  - stall=0 in IDLE when req_valid=0 (non-memory instructions see no penalty).
- Latency: with accept edge at cycle 0, WAIT occupies cycles 1..LATENCY and resp_valid is high in cycle LATENCY+1. A back-to-back request can be accepted at the earliest in cycle LATENCY+2.
- Ordering: strictly one outstanding request. A load following a store to the same word returns the new data.
- Counter width: 4 bits.

Test Plan:
- Reset then idle:
  - Stimulus: rst pulse mid-cycle, req_valid=0 for 10 cycles.
  - Required: req_ready=1, stall=0, resp_valid=0 throughout, asserted asynchronously with rst.
- Store then load, LATENCY=3:
  - Stimulus: store addr 0x40, data 0xDEADBEEF; when the store response arrives, load addr 0x40.
  - Required: stall high in cycles 0..3 of each access, resp_valid in cycle 4, load resp_rdata=0xDEADBEEF, resp_err=0.
- Address wrap, DEPTH_WORDS=1024:
  - Stimulus: store 0x12345678 to 0x1000, then load 0x0000.
  - Required: load returns 0x12345678.
- Misaligned store:
  - Stimulus: store 0xAAAA5555 to 0x42 after word 0x40 holds 0x11111111, then load 0x40.
  - Required: resp_err=1 on the store response; the load returns 0x11111111 with resp_err=0.
- Reset mid-access:
  - Stimulus: store 0xCAFEF00D to 0x80, assert rst during WAIT cycle 2, then load 0x80.
  - Required: no resp_valid for the store; load returns the prior content; state is IDLE immediately after rst.
- LATENCY=1 back-to-back loads:
  - Stimulus: req_valid held high with loads to 0x0, 0x4, 0x8.
  - Required: resp_valid in cycles 2, 5 and 8; req_ready high only in cycles 0, 3 and 6.
